// File: rtl/mac_tree_pipeline_if.sv
// Operand/result stream bundle for mac_tree_pipeline: operand side (in/valid_in/ready_in),
// result side (out/valid_out/ready_out) and the pipeline fill level.
interface mac_tree_pipeline_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_INPUTS = 8
);
  localparam int unsigned LATENCY = 2 + $clog2(NUM_INPUTS / 2);
  localparam int unsigned OCC_W   = $clog2(LATENCY + 1);

  logic [WIDTH-1:0] in [NUM_INPUTS];
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] out;
  logic             valid_out;
  logic             ready_out;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in, valid_in, ready_out,
    input  ready_in, out, valid_out, occupancy
  );

  modport slave (
    input  in, valid_in, ready_out,
    output ready_in, out, valid_out, occupancy
  );
endinterface

// File: rtl/mac_tree_pipeline.sv
// Pipelined multiply-accumulate tree with per-stage valid/ready flow control.
// Stage 0 registers operands, stage 1 pairwise products, later stages halve by pairwise adds.
module mac_tree_pipeline #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_INPUTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_tree_pipeline_if.slave bus
);
  localparam int unsigned LATENCY = 2 + $clog2(NUM_INPUTS / 2);
  localparam int unsigned OCC_W   = $clog2(LATENCY + 1);
  localparam int unsigned SLOTS   = 2 * NUM_INPUTS - 1;

  // All stages share one flat slot array: stage 0 at 0, stage k>=1 follows the halving sizes.
  function automatic int stage_off(input int k);
    if (k == 0) return 0;
    return int'(2 * NUM_INPUTS) - int'(NUM_INPUTS >> (k - 1));
  endfunction

  function automatic int stage_len(input int k);
    if (k == 0) return int'(NUM_INPUTS);
    return int'(NUM_INPUTS >> k);
  endfunction

  logic [WIDTH-1:0]   data_q [SLOTS];
  logic [WIDTH-1:0]   data_d [SLOTS];
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] v_d;
  logic [LATENCY-1:0] en_c;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;

  // A stage may load when it is empty or every stage from it to the output can move.
  always_comb begin
    logic full;
    full = 1'b1;
    en_c = '0;
    for (int k = 0; k < int'(LATENCY); k++) begin
      full = 1'b1;
      for (int j = k; j < int'(LATENCY); j++) begin
        full = full & v_q[j];
      end
      en_c[k] = bus.ready_out | ~full;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a      = '0;
    b      = '0;
    data_d = data_q;
    v_d    = v_q;
    occ_d  = '0;
    if (en_c[0]) begin
      v_d[0] = bus.valid_in;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        data_d[i] = bus.in[i];
      end
    end
    for (int k = 1; k < int'(LATENCY); k++) begin
      if (en_c[k]) begin
        v_d[k] = v_q[k-1];
        for (int j = 0; j < int'(NUM_INPUTS / 2); j++) begin
          if (j < stage_len(k)) begin
            a = data_q[stage_off(k - 1) + 2 * j];
            b = data_q[stage_off(k - 1) + 2 * j + 1];
            data_d[stage_off(k) + j] = (k == 1) ? WIDTH'(a * b) : WIDTH'(a + b);
          end
        end
      end
    end
    for (int k = 0; k < int'(LATENCY); k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        data_q[i] <= '0;
      end
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
      occ_q  <= occ_d;
    end
  end

  assign bus.ready_in  = en_c[0];
  assign bus.out       = data_q[SLOTS-1];
  assign bus.valid_out = v_q[LATENCY-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_mac_tree_pipeline.sv
// Self-checking bench for mac_tree_pipeline: queue-based reference for the 8-input instance,
// plus directed literal checks on 2-, 8- and 16-input instances.
module tb_mac_tree_pipeline;
  localparam int unsigned W    = 16;
  localparam int          LAT8 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_tree_pipeline_if #(.WIDTH(W), .NUM_INPUTS(8))  b8 ();
  mac_tree_pipeline_if #(.WIDTH(W), .NUM_INPUTS(2))  b2 ();
  mac_tree_pipeline_if #(.WIDTH(W), .NUM_INPUTS(16)) b16 ();

  mac_tree_pipeline #(.WIDTH(W), .NUM_INPUTS(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  mac_tree_pipeline #(.WIDTH(W), .NUM_INPUTS(2))  u2  (.clk(clk), .rst(rst), .bus(b2.slave));
  mac_tree_pipeline #(.WIDTH(W), .NUM_INPUTS(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q [$];
  int           xfer_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sum of pairwise products modulo 2^W.
  function automatic logic [W-1:0] mac_ref(input logic [W-1:0] v [8]);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(v[2*i]) * longint'(v[2*i+1]);
    return W'(acc);
  endfunction

  // Every in-flight item occupies exactly one stage, so the queue length is the occupancy.
  always @(negedge clk) begin
    logic [W-1:0] cur [8];
    if (rst) begin
      exp_q.delete();
    end else begin
      check("occupancy", 32'(b8.occupancy), 32'(exp_q.size()));
      check("ready_in", 32'(b8.ready_in), 32'(b8.ready_out || exp_q.size() < LAT8));
      if (exp_q.size() == 0) check("idle_valid_out", 32'(b8.valid_out), 32'd0);
      else if (b8.valid_out) check("out", 32'(b8.out), 32'(exp_q[0]));
      if (b8.valid_out && b8.ready_out && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        xfer_log.push_back(cyc);
      end
      if (b8.valid_in && b8.ready_in) begin
        for (int i = 0; i < 8; i++) cur[i] = b8.in[i];
        exp_q.push_back(mac_ref(cur));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec8(input logic [W-1:0] v [8]);
    for (int i = 0; i < 8; i++) b8.in[i] = v[i];
  endtask

  // One operand vector, ready_out high: result must appear only after LAT8 edges.
  task automatic single_shot(input logic [W-1:0] v [8], input logic [W-1:0] exp, input string name);
    set_vec8(v);
    b8.valid_in = 1'b1;
    for (int n = 1; n <= LAT8 + 2; n++) begin
      tick();
      if (n == 1) b8.valid_in = 1'b0;
      check({name, "_valid"}, 32'(b8.valid_out), 32'(n == LAT8));
      if (n == LAT8) check({name, "_out"}, 32'(b8.out), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, elapsed %0t required below 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v [8];
    logic [W-1:0] vecs [20][8];
    logic [W-1:0] hold_out;
    int idx;
    logic acc;

    for (int i = 0; i < 8; i++) b8.in[i] = '0;
    for (int i = 0; i < 2; i++) b2.in[i] = '0;
    for (int i = 0; i < 16; i++) b16.in[i] = '0;
    b8.valid_in = 1'b0;  b8.ready_out = 1'b1;
    b2.valid_in = 1'b0;  b2.ready_out = 1'b1;
    b16.valid_in = 1'b0; b16.ready_out = 1'b1;

    #12;
    check("rst_out", 32'(b8.out), 32'd0);
    check("rst_valid_out", 32'(b8.valid_out), 32'd0);
    check("rst_occupancy", 32'(b8.occupancy), 32'd0);
    check("rst_ready_in", 32'(b8.ready_in), 32'd1);
    #1 rst = 1'b0;
    tick();

    // Basic MAC: 2+12+30+56.
    for (int i = 0; i < 8; i++) v[i] = W'(i + 1);
    single_shot(v, 16'd100, "basic");

    // Wrap-around: 0xFF*0xFF=0xFE01, pair sums 0xFC02, total 0xF804.
    for (int i = 0; i < 8; i++) v[i] = 16'h00FF;
    single_shot(v, 16'hF804, "wrap");

    // Streaming at full throughput.
    for (int s = 0; s < 20; s++)
      for (int i = 0; i < 8; i++) vecs[s][i] = W'($urandom);
    xfer_log.delete();
    b8.valid_in = 1'b1;
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < 8; i++) v[i] = vecs[s][i];
      set_vec8(v);
      check("stream_ready_in", 32'(b8.ready_in), 32'd1);
      tick();
    end
    b8.valid_in = 1'b0;
    repeat (LAT8 + 2) tick();
    check("stream_count", 32'(xfer_log.size()), 32'd20);
    if (xfer_log.size() == 20) check("stream_span", 32'(xfer_log[19] - xfer_log[0]), 32'd19);

    // Backpressure: pipe fills after four accepts, then holds.
    b8.ready_out = 1'b0;
    b8.valid_in  = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 8; i++) v[i] = vecs[idx][i];
      set_vec8(v);
      @(negedge clk);
      acc = b8.ready_in;
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_occupancy", 32'(b8.occupancy), 32'd4);
    check("bp_ready_in", 32'(b8.ready_in), 32'd0);
    hold_out = b8.out;
    tick();
    tick();
    check("bp_frozen_out", 32'(b8.out), 32'(hold_out));
    check("bp_frozen_valid", 32'(b8.valid_out), 32'd1);
    b8.ready_out = 1'b1;
    #1;
    check("full_pass_ready_in", 32'(b8.ready_in), 32'd1);
    tick();
    check("full_pass_occupancy", 32'(b8.occupancy), 32'd4);
    b8.valid_in = 1'b0;
    repeat (LAT8 + 2) tick();
    check("bp_drained", 32'(b8.occupancy), 32'd0);

    // Bubble squeeze: sparse inputs under stall collapse into a full pipe.
    b8.ready_out = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++) v[i] = W'(c * 8 + i + 3);
      set_vec8(v);
      b8.valid_in = (c % 2 == 0);
      tick();
    end
    b8.valid_in = 1'b0;
    check("bubble_occupancy", 32'(b8.occupancy), 32'd4);
    b8.ready_out = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check("bubble_burst_valid", 32'(b8.valid_out), 32'd1);
      tick();
    end
    check("bubble_burst_end", 32'(b8.valid_out), 32'd0);

    // Async reset with three results in flight, one already at the output.
    b8.ready_out = 1'b0;
    b8.valid_in  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) v[i] = W'(c + i + 1);
      set_vec8(v);
      tick();
    end
    b8.valid_in = 1'b0;
    tick();
    check("pre_rst_occupancy", 32'(b8.occupancy), 32'd3);
    check("pre_rst_valid_out", 32'(b8.valid_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid_out", 32'(b8.valid_out), 32'd0);
    check("async_rst_out", 32'(b8.out), 32'd0);
    check("async_rst_occupancy", 32'(b8.occupancy), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    b8.ready_out = 1'b1;
    for (int n = 0; n < 6; n++) begin
      check("post_rst_no_stale", 32'(b8.valid_out), 32'd0);
      tick();
    end

    // Other sizes: {3,5} -> 15 after 2 stages; sixteen ones -> 8 after 5 stages.
    b2.in[0] = 16'd3;
    b2.in[1] = 16'd5;
    for (int i = 0; i < 16; i++) b16.in[i] = 16'd1;
    b2.valid_in  = 1'b1;
    b16.valid_in = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 1) begin
        b2.valid_in  = 1'b0;
        b16.valid_in = 1'b0;
      end
      check("n2_valid", 32'(b2.valid_out), 32'(n == 2));
      if (n == 2) check("n2_out", 32'(b2.out), 32'd15);
      check("n16_valid", 32'(b16.valid_out), 32'(n == 5));
      if (n == 5) check("n16_out", 32'(b16.out), 32'd8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
